pulse_pattern_generator: RTL and testbench

PULSE_PATTERN_GENERATOR -- requirements
Module: pulse_pattern_generator

---
 rtl/pulse_gen_pkg.sv | 14 +
 rtl/pulse_pattern_generator_if.sv | 25 ++
 rtl/phase_counter.sv | 40 ++++
 rtl/pulse_pattern_generator.sv | 133 +++++++++++++
 tb/tb_pulse_pattern_generator.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/pulse_gen_pkg.sv
// rtl/pulse_gen_pkg.sv - shared state type and default width for the pulse pattern generator
package pulse_gen_pkg;

  localparam int DEFAULT_W = 8;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LEAD = 3'd1,
    HIGH = 3'd2,
    LOW  = 3'd3,
    DONE = 3'd4
  } state_e;

endpackage

// File: rtl/pulse_pattern_generator_if.sv
// rtl/pulse_pattern_generator_if.sv - request/status bundle between a requester and the generator
interface pulse_pattern_generator_if #(
  parameter int W = pulse_gen_pkg::DEFAULT_W
);

  logic         start;
  logic [W-1:0] high_len;
  logic [W-1:0] low_len;
  logic [W-1:0] count;
  logic         abort;
  logic         ready;
  logic         out;
  logic         done;

  modport master (
    output start, high_len, low_len, count, abort,
    input  ready, out, done
  );

  modport slave (
    input  start, high_len, low_len, count, abort,
    output ready, out, done
  );

endinterface

// File: rtl/phase_counter.sv
// rtl/phase_counter.sv - loadable W-bit phase-length down-counter with zero flag
module phase_counter #(
  parameter int W = pulse_gen_pkg::DEFAULT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Clear wins over load; decrement holds at zero so the counter never wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/pulse_pattern_generator.sv
// rtl/pulse_pattern_generator.sv - lead-in, N high/low pulses, then a one-cycle done strobe
module pulse_pattern_generator
  import pulse_gen_pkg::*;
#(
  parameter int W = DEFAULT_W
) (
  input  logic                        clk,
  input  logic                        rst_n,
  pulse_pattern_generator_if.slave    bus
);

  localparam logic [W-1:0] ONE = W'(1);

  state_e       state_q, state_d;
  logic [W-1:0] high_q, high_d;
  logic [W-1:0] low_q, low_d;
  logic [W-1:0] pulse_q, pulse_d;
  logic         out_q, out_d;

  logic         ph_clr;
  logic         ph_load;
  logic [W-1:0] ph_val;
  logic         ph_dec;
  logic         ph_zero;

  // Zero lengths behave as one cycle so every phase is visible.
  logic [W-1:0] high_in;
  logic [W-1:0] low_in;
  assign high_in = (bus.high_len == '0) ? ONE : bus.high_len;
  assign low_in  = (bus.low_len  == '0) ? ONE : bus.low_len;

  // The phase counter is loaded with length-1 so its zero flag marks the last cycle of a phase.
  phase_counter #(.W(W)) u_phase (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (ph_clr),
    .load     (ph_load),
    .load_val (ph_val),
    .dec      (ph_dec),
    .zero     (ph_zero)
  );

  assign ph_dec = (state_q != IDLE);

  // Next-state, field latching and phase-counter control; out is registered from the next state.
  always_comb begin
    state_d = state_q;
    high_d  = high_q;
    low_d   = low_q;
    pulse_d = pulse_q;
    ph_clr  = 1'b0;
    ph_load = 1'b0;
    ph_val  = '0;

    if ((state_q != IDLE) && bus.abort) begin
      state_d = IDLE;
      ph_clr  = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start && !bus.abort) begin
            high_d  = high_in;
            low_d   = low_in;
            pulse_d = bus.count;
            ph_load = 1'b1;
            ph_val  = low_in - ONE;
            state_d = LEAD;
          end
        end
        LEAD: begin
          if (ph_zero) begin
            if (pulse_q == '0) begin
              state_d = DONE;
            end else begin
              ph_load = 1'b1;
              ph_val  = high_q - ONE;
              state_d = HIGH;
            end
          end
        end
        HIGH: begin
          if (ph_zero) begin
            pulse_d = pulse_q - ONE;
            ph_load = 1'b1;
            ph_val  = low_q - ONE;
            state_d = LOW;
          end
        end
        LOW: begin
          if (ph_zero) begin
            if (pulse_q == '0) begin
              state_d = DONE;
            end else begin
              ph_load = 1'b1;
              ph_val  = high_q - ONE;
              state_d = HIGH;
            end
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    out_d = (state_d == HIGH);
  end

  // State, latched fields, pulse counter and output flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      high_q  <= '0;
      low_q   <= '0;
      pulse_q <= '0;
      out_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      high_q  <= high_d;
      low_q   <= low_d;
      pulse_q <= pulse_d;
      out_q   <= out_d;
    end
  end

  assign bus.ready = (state_q == IDLE);
  assign bus.done  = (state_q == DONE);
  assign bus.out   = out_q;

endmodule

// File: tb/tb_pulse_pattern_generator.sv
// tb/tb_pulse_pattern_generator.sv - scoreboard bench for the pulse pattern generator
module tb_pulse_pattern_generator;

  typedef struct packed {
    logic out;
    logic done;
    logic ready;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;
  exp_t exp_q[$];

  pulse_pattern_generator_if #(.W(8)) bus ();

  pulse_pattern_generator #(.W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pop_and_check(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      check_val({tag, " queue_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check_val({tag, " out"},   32'(bus.out),   32'(e.out));
      check_val({tag, " done"},  32'(bus.done),  32'(e.done));
      check_val({tag, " ready"}, 32'(bus.ready), 32'(e.ready));
    end
  endtask

  // Called at posedge+1 in an idle cycle t. again_at/abort_at are cycle offsets from t (-1 = never).
  task automatic run_pattern(input string name, input int h, input int l, input int c,
                             input int again_at, input int abort_at, input bit check_runs);
    int   hh;
    int   ll;
    int   n;
    int   run;
    int   min_run;
    exp_t seq[$];
    hh = (h == 0) ? 1 : h;
    ll = (l == 0) ? 1 : l;
    seq.push_back('{out: 1'b0, done: 1'b0, ready: 1'b1});
    repeat (ll) seq.push_back('{out: 1'b0, done: 1'b0, ready: 1'b0});
    repeat (c) begin
      repeat (hh) seq.push_back('{out: 1'b1, done: 1'b0, ready: 1'b0});
      repeat (ll) seq.push_back('{out: 1'b0, done: 1'b0, ready: 1'b0});
    end
    seq.push_back('{out: 1'b0, done: 1'b1, ready: 1'b0});
    repeat (3) seq.push_back('{out: 1'b0, done: 1'b0, ready: 1'b1});
    if (abort_at > 0) begin
      while (seq.size() > abort_at + 1) void'(seq.pop_back());
      repeat (4) seq.push_back('{out: 1'b0, done: 1'b0, ready: 1'b1});
    end
    foreach (seq[i]) exp_q.push_back(seq[i]);
    n = seq.size();

    bus.high_len = 8'(h);
    bus.low_len  = 8'(l);
    bus.count    = 8'(c);
    bus.start    = 1'b1;
    bus.abort    = 1'b0;
    run     = 0;
    min_run = 1000;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (bus.out === 1'b1) begin
        run++;
      end else begin
        if (run > 0 && run < min_run) min_run = run;
        run = 0;
      end
      pop_and_check($sformatf("%s@t+%0d", name, k));
      @(posedge clk);
      #1;
      bus.start = (k + 1 == again_at);
      bus.abort = (k + 1 == abort_at);
      if (k == 0) begin
        bus.high_len = 8'hff;
        bus.low_len  = 8'hff;
        bus.count    = 8'hff;
      end
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;
    if (check_runs) check_val({name, " min_high_run"}, 32'(min_run), 32'(hh));
  endtask

  initial begin
    n_vec        = 0;
    n_err        = 0;
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.abort    = 1'b0;
    bus.high_len = '0;
    bus.low_len  = '0;
    bus.count    = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("reset out",   32'(bus.out),   32'd0);
    check_val("reset done",  32'(bus.done),  32'd0);
    check_val("reset ready", 32'(bus.ready), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // First start right after reset release; a start during the done cycle is ignored.
    run_pattern("h1l1c2", 1, 1, 2, 6, -1, 1'b0);
    run_pattern("h3l2c1", 3, 2, 1, -1, -1, 1'b1);
    run_pattern("h0l0c3", 0, 0, 3, 8, -1, 1'b0);
    run_pattern("c0l4",   5, 4, 0, 5, -1, 1'b0);
    run_pattern("abort",  1, 1, 4, 2, 3, 1'b0);

    // Abort together with start in idle: nothing is accepted.
    bus.high_len = 8'd1;
    bus.low_len  = 8'd1;
    bus.count    = 8'd1;
    bus.start    = 1'b1;
    bus.abort    = 1'b1;
    repeat (4) exp_q.push_back('{out: 1'b0, done: 1'b0, ready: 1'b1});
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      pop_and_check($sformatf("abort_start_idle@%0d", k));
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.abort = 1'b0;
    end

    // Reset pulled low in the middle of a high phase.
    bus.high_len = 8'd2;
    bus.low_len  = 8'd1;
    bus.count    = 8'd3;
    bus.start    = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    check_val("pre_reset out", 32'(bus.out), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check_val("async_reset out",   32'(bus.out),   32'd0);
    check_val("async_reset ready", 32'(bus.ready), 32'd1);
    check_val("async_reset done",  32'(bus.done),  32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_pattern("after_reset", 2, 1, 3, -1, -1, 1'b1);

    // A few randomized patterns.
    for (int r = 0; r < 4; r++) begin
      run_pattern($sformatf("rand%0d", r), int'($urandom_range(0, 4)),
                  int'($urandom_range(0, 4)), int'($urandom_range(0, 3)), -1, -1, 1'b0);
    end

    check_val("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
